// File: rtl/ofdm_rx_pkg.sv
// Shared types and constants for the OFDM receive front end.
// Writer/reader state codes, default symbol geometry and the signed sample type.
package ofdm_rx_pkg;

    localparam int unsigned SYM_LEN_DEF = 64;
    localparam int unsigned SYM_NUM_DEF = 15;

    typedef logic signed [7:0] sample_t;

    localparam logic [1:0] WR_IDLE    = 2'd0;
    localparam logic [1:0] WR_CAPTURE = 2'd1;
    localparam logic [1:0] WR_DONE    = 2'd2;

    localparam logic [1:0] RD_WAIT    = 2'd0;
    localparam logic [1:0] RD_HDR     = 2'd1;
    localparam logic [1:0] RD_PAYLOAD = 2'd2;

    // Unsigned magnitude; -128 maps to 128, which still fits in 8 bits.
    function automatic logic [7:0] sample_mag(input sample_t s);
        logic [7:0] u;
        u = s;
        return s[7] ? (~u + 8'd1) : u;
    endfunction

endpackage

// File: rtl/rx_pingpong_buf.sv
// Two-bank symbol buffer: SYM_LEN x 8 per bank, one write and one read port,
// with a full flag per bank set by the writer and cleared by the reader.
module rx_pingpong_buf #(
    parameter int unsigned SymLen = 64,
    parameter int unsigned AW     = (SymLen > 1) ? $clog2(SymLen) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic          wr_buf_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          set_full_i,
    input  logic          rd_buf_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          clr_full_i,
    output logic [7:0]    rd_data_o,
    output logic [1:0]    full_o
);

    logic [7:0] mem [2**(AW+1)];
    logic [1:0] full_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[{wr_buf_i, wr_addr_i}] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[{rd_buf_i, rd_addr_i}];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 2'b00;
        end else begin
            if (clr_full_i) full_q[rd_buf_i] <= 1'b0;
            if (set_full_i) full_q[wr_buf_i] <= 1'b1;
        end
    end

    assign full_o = full_q;

endmodule

// File: rtl/ofdm_rx_top.sv
// OFDM RX front end: ADC clock generation, ping-pong symbol capture and AXI-Stream framing.
// Optional SYNC_DETECT_EN: capture starts only on a sample whose magnitude reaches THRESH.
module ofdm_rx_top
    import ofdm_rx_pkg::*;
#(
    parameter int unsigned ADC_DIV = 4,
    parameter int unsigned SYM_LEN = SYM_LEN_DEF,
    parameter int unsigned SYM_NUM = SYM_NUM_DEF,
    parameter int unsigned THRESH  = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] adc_data,
    output logic        adc_clk,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        overflow,
    output logic        frame_done
);

    localparam int unsigned HALF = ADC_DIV / 2;
    localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned AW   = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam int unsigned SW   = (SYM_NUM > 1) ? $clog2(SYM_NUM) : 1;

    logic [CW-1:0] div_cnt_q;
    logic          adc_clk_q, div_wrap, sample_stb;
    sample_t       sample;
    logic          trigger, unused_hi;

    logic [1:0]    wr_state_q, wr_state_d;
    logic          wr_buf_q, wr_buf_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [SW-1:0] wr_sym_q, wr_sym_d;
    logic          overflow_q, overflow_d;
    logic          accept, wr_en, set_full, wr_blocked;

    logic [1:0]    rd_state_q, rd_state_d;
    logic          rd_buf_q, rd_buf_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d, rd_addr;
    logic [SW-1:0] sym_q, sym_d;
    logic          tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
    logic [7:0]    tdata_q, tdata_d, rd_data;
    logic          frame_done_q, frame_done_d;
    logic          rd_clr, handshake, last_sym;
    logic [1:0]    full;

    assign unused_hi = ^adc_data[15:8];
    assign sample    = sample_t'(adc_data[7:0]);

`ifdef SYNC_DETECT_EN
    assign trigger = (32'(sample_mag(sample)) >= THRESH);
`else
    logic unused_thresh;
    assign unused_thresh = (THRESH != 0);
    assign trigger       = 1'b1;
`endif

    assign div_wrap   = (div_cnt_q == CW'(HALF - 1));
    assign sample_stb = div_wrap && !adc_clk_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt_q <= '0;
            adc_clk_q <= 1'b0;
        end else if (div_wrap) begin
            div_cnt_q <= '0;
            adc_clk_q <= ~adc_clk_q;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    // A buffer freed this cycle is writable this cycle.
    assign wr_blocked = full[wr_buf_q] && !(rd_clr && (rd_buf_q == wr_buf_q));

    always_comb begin
        wr_state_d = wr_state_q;
        wr_buf_d   = wr_buf_q;
        wr_addr_d  = wr_addr_q;
        wr_sym_d   = wr_sym_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        set_full   = 1'b0;
        accept     = sample_stb &&
                     ((wr_state_q == WR_CAPTURE) || ((wr_state_q == WR_IDLE) && trigger));
        if (accept) begin
            if (wr_blocked) begin
                overflow_d = 1'b1;
            end else begin
                wr_en      = 1'b1;
                wr_state_d = WR_CAPTURE;
                if (wr_addr_q == AW'(SYM_LEN - 1)) begin
                    set_full  = 1'b1;
                    wr_buf_d  = ~wr_buf_q;
                    wr_addr_d = '0;
                    if (wr_sym_q == SW'(SYM_NUM - 1)) begin
                        wr_sym_d   = '0;
                        wr_state_d = WR_DONE;
                    end else begin
                        wr_sym_d = wr_sym_q + 1'b1;
                    end
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
        end
        if ((wr_state_q == WR_DONE) && frame_done_q) wr_state_d = WR_IDLE;
    end

    assign handshake = tvalid_q && m_axis_tready;
    assign last_sym  = (sym_q == SW'(SYM_NUM - 1));
    assign rd_addr   = (rd_state_q == RD_HDR) ? '0 : rd_addr_q + 1'b1;

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_buf_d     = rd_buf_q;
        rd_addr_d    = rd_addr_q;
        sym_d        = sym_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tuser_d      = tuser_q;
        tlast_d      = tlast_q;
        frame_done_d = 1'b0;
        rd_clr       = 1'b0;
        case (rd_state_q)
            RD_WAIT: begin
                if (full[rd_buf_q]) begin
                    tvalid_d   = 1'b1;
                    tdata_d    = 8'(sym_q);
                    tuser_d    = (sym_q == '0);
                    tlast_d    = 1'b0;
                    rd_state_d = RD_HDR;
                end
            end
            RD_HDR: begin
                if (handshake) begin
                    tdata_d    = rd_data;
                    tuser_d    = 1'b0;
                    tlast_d    = last_sym && (SYM_LEN == 1);
                    rd_addr_d  = '0;
                    rd_state_d = RD_PAYLOAD;
                end
            end
            RD_PAYLOAD: begin
                if (handshake) begin
                    if (rd_addr_q == AW'(SYM_LEN - 1)) begin
                        tvalid_d   = 1'b0;
                        tlast_d    = 1'b0;
                        rd_clr     = 1'b1;
                        rd_buf_d   = ~rd_buf_q;
                        rd_state_d = RD_WAIT;
                        if (last_sym) begin
                            sym_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            sym_d = sym_q + 1'b1;
                        end
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        tdata_d   = rd_data;
                        tlast_d   = last_sym && (rd_addr_q == AW'(SYM_LEN - 2));
                    end
                end
            end
            default: rd_state_d = RD_WAIT;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_state_q   <= WR_IDLE;
            wr_buf_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_sym_q     <= '0;
            overflow_q   <= 1'b0;
            rd_state_q   <= RD_WAIT;
            rd_buf_q     <= 1'b0;
            rd_addr_q    <= '0;
            sym_q        <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= 8'd0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_buf_q     <= wr_buf_d;
            wr_addr_q    <= wr_addr_d;
            wr_sym_q     <= wr_sym_d;
            overflow_q   <= overflow_d;
            rd_state_q   <= rd_state_d;
            rd_buf_q     <= rd_buf_d;
            rd_addr_q    <= rd_addr_d;
            sym_q        <= sym_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            frame_done_q <= frame_done_d;
        end
    end

    rx_pingpong_buf #(
        .SymLen (SYM_LEN),
        .AW     (AW)
    ) u_buf (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .wr_en_i    (wr_en),
        .wr_buf_i   (wr_buf_q),
        .wr_addr_i  (wr_addr_q),
        .wr_data_i  (adc_data[7:0]),
        .set_full_i (set_full),
        .rd_buf_i   (rd_buf_q),
        .rd_addr_i  (rd_addr),
        .clr_full_i (rd_clr),
        .rd_data_o  (rd_data),
        .full_o     (full)
    );

    assign adc_clk       = adc_clk_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign overflow      = overflow_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_ofdm_rx_top.sv
// Bench for ofdm_rx_top: frame-level byte model plus directed ramp/stall/overflow/sync/reset runs.
// Build with or without SYNC_DETECT_EN; the model follows the same macro.
module tb_ofdm_rx_top;

    localparam int NSAMP  = 1400;
    localparam int NBYTES = 15 * 65;

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } beat_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] adc_data = 16'd0;
    logic        adc_clk;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        overflow;
    logic        frame_done;

    int    errors = 0;
    int    checks = 0;
    int    samples [NSAMP];
    beat_t exp_q [$];
    int    gen_idx = 0;
    bit    cmp_en = 1'b0;
    int    cmp_mode = 0;
    int    rdy_mode = 0;
    int    rdy_cyc = 0;
    int    nbytes, gaps, last_payload, first_payload, last_data, exp_hdr, pkt_pos;
    bit    prev_stall, prev_hs_last, ov_seen;
    logic [7:0] prev_data;
    logic  prev_user, prev_last;

    ofdm_rx_top #(
        .ADC_DIV (4),
        .SYM_LEN (64),
        .SYM_NUM (15),
        .THRESH  (16)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .adc_data      (adc_data),
        .adc_clk       (adc_clk),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .overflow      (overflow),
        .frame_done    (frame_done)
    );

    initial forever #5 sys_clk = ~sys_clk;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Next ADC sample is presented after each falling adc_clk edge, one per rising edge.
    initial forever begin
        @(negedge adc_clk);
        #1;
        if (!sys_rst) begin
            gen_idx++;
            adc_data = {8'hA5, 8'(samples[(gen_idx < NSAMP) ? gen_idx : NSAMP - 1])};
        end
    end

    initial forever begin
        @(posedge sys_clk);
        #1;
        rdy_cyc++;
        case (rdy_mode)
            1:       m_axis_tready = ~m_axis_tready;
            2:       m_axis_tready = (rdy_cyc >= 768);
            default: m_axis_tready = 1'b1;
        endcase
    end

    // Expected stream: 15 packets of header + 64 consecutive captured samples.
    task automatic build_exp(input int start);
        beat_t b;
        exp_q.delete();
        for (int s = 0; s < 15; s++) begin
            b.d = 8'(s);
            b.u = (s == 0);
            b.l = 1'b0;
            exp_q.push_back(b);
            for (int j = 0; j < 64; j++) begin
                b.d = 8'(samples[start + s * 64 + j]);
                b.u = 1'b0;
                b.l = (s == 14) && (j == 63);
                exp_q.push_back(b);
            end
        end
    endtask

    function automatic int first_trigger();
`ifdef SYNC_DETECT_EN
        for (int k = 0; k < NSAMP; k++) begin
            int v;
            v = (samples[k] >= 128) ? 256 - samples[k] : samples[k];
            if (v >= 16) return k;
        end
`endif
        return 0;
    endfunction

    always @(negedge sys_clk) begin
        if (sys_rst || !cmp_en) begin
            prev_stall   = 1'b0;
            prev_hs_last = 1'b0;
            ov_seen      = 1'b0;
        end else begin
            if (frame_done || prev_hs_last)
                chk(frame_done == prev_hs_last, "frame_done_pulse", frame_done, prev_hs_last);
            if (prev_stall) begin
                chk(m_axis_tvalid, "hold_tvalid", m_axis_tvalid, 1);
                chk(m_axis_tdata == prev_data && m_axis_tuser == prev_user &&
                    m_axis_tlast == prev_last, "hold_data", m_axis_tdata, prev_data);
            end
            if (ov_seen) chk(overflow, "overflow_sticky", overflow, 1);
            if (overflow) ov_seen = 1'b1;
            if (m_axis_tvalid && m_axis_tready) begin
                if (cmp_mode == 0) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "extra_byte", m_axis_tdata, -1);
                    end else begin
                        beat_t b;
                        b = exp_q.pop_front();
                        chk(m_axis_tdata == b.d, $sformatf("byte%0d_data", nbytes),
                            m_axis_tdata, b.d);
                        chk(m_axis_tuser == b.u, $sformatf("byte%0d_tuser", nbytes),
                            m_axis_tuser, b.u);
                        chk(m_axis_tlast == b.l, $sformatf("byte%0d_tlast", nbytes),
                            m_axis_tlast, b.l);
                    end
                end else begin
                    if (pkt_pos == 0) begin
                        chk(m_axis_tdata == 8'(exp_hdr), "ov_hdr", m_axis_tdata, exp_hdr);
                        chk(m_axis_tuser == (exp_hdr == 0), "ov_tuser", m_axis_tuser,
                            exp_hdr == 0);
                        chk(!m_axis_tlast, "ov_hdr_tlast", m_axis_tlast, 0);
                    end else begin
                        int diff;
                        diff = (int'(m_axis_tdata) - last_payload) & 255;
                        chk(diff != 0, "ov_order", m_axis_tdata, (last_payload + 1) & 255);
                        if (diff > 1) gaps++;
                        last_payload = m_axis_tdata;
                        chk(m_axis_tlast == (exp_hdr == 14 && pkt_pos == 64), "ov_tlast",
                            m_axis_tlast, exp_hdr == 14 && pkt_pos == 64);
                    end
                    pkt_pos++;
                    if (pkt_pos == 65) begin
                        pkt_pos = 0;
                        exp_hdr++;
                    end
                end
                if (nbytes == 1) first_payload = m_axis_tdata;
                last_data = m_axis_tdata;
                nbytes++;
            end
            prev_stall   = m_axis_tvalid && !m_axis_tready;
            prev_hs_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;
            prev_data    = m_axis_tdata;
            prev_user    = m_axis_tuser;
            prev_last    = m_axis_tlast;
        end
    end

    task automatic start_frame(input int rdy, input int cmode, input bit chk_adc);
        int pat [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
        cmp_en  = 1'b0;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk(!m_axis_tvalid, "rst_tvalid", m_axis_tvalid, 0);
        chk({adc_clk, m_axis_tdata, m_axis_tlast, m_axis_tuser, overflow, frame_done} == 0,
            "rst_outputs", {adc_clk, m_axis_tdata, m_axis_tlast, m_axis_tuser, overflow,
            frame_done}, 0);
        repeat (2) @(negedge sys_clk);
        build_exp(first_trigger());
        nbytes        = 0;
        gaps          = 0;
        last_payload  = 255;
        first_payload = -1;
        last_data     = -1;
        exp_hdr       = 0;
        pkt_pos       = 0;
        rdy_mode      = rdy;
        cmp_mode      = cmode;
        rdy_cyc       = 0;
        gen_idx       = 0;
        adc_data      = {8'hA5, 8'(samples[0])};
        sys_rst       = 1'b0;
        cmp_en        = 1'b1;
        if (chk_adc) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge sys_clk);
                chk(adc_clk == pat[i][0], $sformatf("adc_clk_c%0d", i), adc_clk, pat[i]);
            end
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        while (!frame_done && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        chk(frame_done, "frame_done_timeout", n, 20000);
    endtask

    task automatic end_checks(input bit want_ov);
        chk(nbytes == NBYTES, "byte_count", nbytes, NBYTES);
        chk(overflow == want_ov, "overflow_end", overflow, want_ov);
        if (cmp_mode == 0) chk(exp_q.size() == 0, "missing_bytes", exp_q.size(), 0);
    endtask

    initial begin
        for (int k = 0; k < NSAMP; k++) samples[k] = k & 255;

        // Ramp with tready held high.
        start_frame(0, 0, 1'b1);
        wait_frame();
        end_checks(1'b0);
        chk(last_data == 8'hBF, "ramp_last_byte", last_data, 8'hBF);
        chk(first_payload == 0, "ramp_first_payload", first_payload, 0);

        // Same ramp with tready toggling every cycle.
        start_frame(1, 0, 1'b0);
        wait_frame();
        end_checks(1'b0);
        chk(last_data == 8'hBF, "toggle_last_byte", last_data, 8'hBF);

        // Downstream blocked for three symbol periods: samples must be dropped.
        start_frame(2, 1, 1'b0);
        wait_frame();
        end_checks(1'b1);
        chk(gaps > 0, "ov_gap_seen", gaps, 1);

        // Low-level preamble followed by a strong sample.
        for (int k = 0; k < NSAMP; k++) samples[k] = (k < 100) ? 5 : (k == 100) ? 40 : (k & 255);
        start_frame(0, 0, 1'b0);
        wait_frame();
        end_checks(1'b0);
`ifdef SYNC_DETECT_EN
        chk(first_payload == 40, "sync_first_payload", first_payload, 40);
`else
        chk(first_payload == 5, "nosync_first_payload", first_payload, 5);
`endif

        // Reset in the middle of a payload, then a fresh frame.
        for (int k = 0; k < NSAMP; k++) samples[k] = k & 255;
        start_frame(0, 0, 1'b0);
        begin
            int n = 0;
            while (nbytes < 100 && n < 5000) begin
                @(negedge sys_clk);
                n++;
            end
            chk(nbytes >= 100, "mid_payload_timeout", nbytes, 100);
            chk(m_axis_tvalid, "mid_payload_tvalid", m_axis_tvalid, 1);
        end
        start_frame(0, 0, 1'b0);
        wait_frame();
        end_checks(1'b0);
        chk(last_data == 8'hBF, "post_reset_last_byte", last_data, 8'hBF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
